// File: rtl/nox_utils_pkg.sv
// rtl/nox_utils_pkg.sv - shared types and helpers for core reset sequencing
package nox_utils_pkg;

    typedef enum logic [1:0] {
        RST_SEQ_IDLE,
        RST_SEQ_DRAIN,
        RST_SEQ_HOLD
    } rst_seq_state_t;

    // One spare bit above the largest count keeps the counter from ever wrapping.
    function automatic int rst_seq_cnt_width(input int hold_cycles, input int drain_timeout);
        int max_cnt;
        max_cnt = (hold_cycles > drain_timeout) ? hold_cycles : drain_timeout;
        return $clog2(max_cnt) + 1;
    endfunction

endpackage

// File: rtl/core_rst_seq.sv
// rtl/core_rst_seq.sv - core reset sequencer: drain the bus, hold reset, present boot vector
module core_rst_seq
    import nox_utils_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rst_addr_i,
    input  logic        sw_rst_req_i,
    input  logic        bus_idle_i,
    output logic        core_rst_o,
    output logic [31:0] boot_addr_o,
    output logic        busy_o,
    output logic        timeout_o
);

    localparam int CNT_W = rst_seq_cnt_width(HOLD_CYCLES, DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    rst_seq_state_t   state_ff;
    rst_seq_state_t   state_nx;
    logic [CNT_W-1:0] cnt_ff;
    logic [CNT_W-1:0] cnt_nx;
    logic [31:0]      addr_seen_ff;
    logic [31:0]      boot_addr_nx;
    logic             timeout_nx;
    logic             trigger;

    assign trigger = sw_rst_req_i || (rst_addr_i != addr_seen_ff);

    always_comb begin
        state_nx     = state_ff;
        cnt_nx       = cnt_ff;
        boot_addr_nx = boot_addr_o;
        timeout_nx   = 1'b0;
        case (state_ff)
            RST_SEQ_IDLE: begin
                if (trigger) begin
                    state_nx = RST_SEQ_DRAIN;
                    cnt_nx   = '0;
                end
            end
            RST_SEQ_DRAIN: begin
                // Triggers are dropped here: the pending sequence already covers them.
                if (bus_idle_i) begin
                    state_nx = RST_SEQ_HOLD;
                    cnt_nx   = HOLD_LOAD;
                end else if (cnt_ff == DRAIN_LAST) begin
                    state_nx   = RST_SEQ_HOLD;
                    cnt_nx     = HOLD_LOAD;
                    timeout_nx = 1'b1;
                end else begin
                    cnt_nx = cnt_ff + CNT_W'(1);
                end
            end
            RST_SEQ_HOLD: begin
                if (trigger) begin
                    cnt_nx = HOLD_LOAD;
                end else if (cnt_ff == '0) begin
                    state_nx     = RST_SEQ_IDLE;
                    boot_addr_nx = rst_addr_i;
                end else begin
                    cnt_nx = cnt_ff - CNT_W'(1);
                end
            end
            default: begin
                state_nx = RST_SEQ_HOLD;
                cnt_nx   = HOLD_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        addr_seen_ff <= rst_addr_i;
        if (rst) begin
            state_ff    <= RST_SEQ_HOLD;
            cnt_ff      <= HOLD_LOAD;
            core_rst_o  <= 1'b1;
            boot_addr_o <= '0;
            busy_o      <= 1'b1;
            timeout_o   <= 1'b0;
        end else begin
            state_ff    <= state_nx;
            cnt_ff      <= cnt_nx;
            core_rst_o  <= (state_nx == RST_SEQ_HOLD);
            boot_addr_o <= boot_addr_nx;
            busy_o      <= (state_nx != RST_SEQ_IDLE);
            timeout_o   <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_core_rst_seq.sv
// tb/tb_core_rst_seq.sv - directed self-checking bench for core_rst_seq
module tb_core_rst_seq;

    logic        clk = 1'b0;
    logic        rst, sw, idle;
    logic [31:0] addr;
    logic        core_rst, busy, timeout;
    logic [31:0] boot;

    logic        rst2, sw2, idle2;
    logic [31:0] addr2;
    logic        core_rst2, busy2, timeout2;
    logic [31:0] boot2;

    int checks = 0;
    int errors = 0;
    int n, hi, pulses;

    always #5 clk = ~clk;

    core_rst_seq #(.HOLD_CYCLES(16), .DRAIN_TIMEOUT(256)) dut (
        .clk(clk), .rst(rst), .rst_addr_i(addr), .sw_rst_req_i(sw), .bus_idle_i(idle),
        .core_rst_o(core_rst), .boot_addr_o(boot), .busy_o(busy), .timeout_o(timeout)
    );

    core_rst_seq #(.HOLD_CYCLES(1), .DRAIN_TIMEOUT(1)) dut_min (
        .clk(clk), .rst(rst2), .rst_addr_i(addr2), .sw_rst_req_i(sw2), .bus_idle_i(idle2),
        .core_rst_o(core_rst2), .boot_addr_o(boot2), .busy_o(busy2), .timeout_o(timeout2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst  = 1'b1; sw  = 1'b0; idle  = 1'b1; addr  = 32'h8000_0000;
        rst2 = 1'b1; sw2 = 1'b0; idle2 = 1'b1; addr2 = 32'h0000_1000;
        repeat (3) step();
        chk("rst_core_rst", core_rst, 1);
        chk("rst_busy", busy, 1);
        chk("rst_boot", boot, 0);
        chk("rst_timeout", timeout, 0);

        // Minimum parameters: one-cycle hold, one-cycle drain timeout
        rst2 = 1'b0;
        n = 0;
        for (int i = 0; i < 10 && core_rst2; i++) begin step(); n++; end
        chk("min_release_high", n, 1);
        chk("min_release_boot", boot2, 32'h0000_1000);
        idle2 = 1'b0; sw2 = 1'b1;
        step();
        sw2 = 1'b0;
        chk("min_drain_busy", busy2, 1);
        chk("min_drain_core", core_rst2, 0);
        step();
        chk("min_timeout_pulse", timeout2, 1);
        chk("min_hold_core", core_rst2, 1);
        step();
        chk("min_timeout_end", timeout2, 0);
        chk("min_hold_end", core_rst2, 0);

        // Reset release: 16-cycle hold then boot from register value
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && core_rst; i++) begin step(); n++; end
        chk("release_high_cycles", n, 16);
        chk("release_boot", boot, 32'h8000_0000);
        repeat (5) step();
        chk("release_no_spurious", busy, 0);

        // Address change in IDLE with idle bus
        addr = 32'hA000_0000;
        step();
        chk("addr_drain_busy", busy, 1);
        chk("addr_drain_core", core_rst, 0);
        step();
        chk("addr_hold_core", core_rst, 1);
        chk("addr_boot_stable", boot, 32'h8000_0000);
        hi = 1;
        for (int i = 0; i < 100 && core_rst; i++) begin step(); if (core_rst) hi++; end
        chk("addr_high_cycles", hi, 16);
        chk("addr_boot_new", boot, 32'hA000_0000);
        chk("addr_idle_busy", busy, 0);

        // Software request with a busy bus: drain timeout
        idle = 1'b0; sw = 1'b1;
        step();
        sw = 1'b0;
        chk("to_drain_core", core_rst, 0);
        n = 0;
        for (int i = 0; i < 400 && !timeout; i++) begin step(); n++; end
        chk("to_latency", n, 256);
        chk("to_hold_core", core_rst, 1);
        hi = 1; pulses = 1;
        for (int i = 0; i < 100 && core_rst; i++) begin
            step();
            if (core_rst) hi++;
            if (timeout) pulses++;
        end
        chk("to_high_cycles", hi, 16);
        chk("to_pulse_count", pulses, 1);
        idle = 1'b1;

        // Re-trigger in HOLD at counter 3 extends the hold
        sw = 1'b1;
        step();
        sw = 1'b0;
        step();
        chk("ext_hold_core", core_rst, 1);
        hi = 1;
        repeat (12) begin step(); if (core_rst) hi++; end
        sw = 1'b1;
        step();
        sw = 1'b0;
        if (core_rst) hi++;
        for (int i = 0; i < 100 && core_rst; i++) begin step(); if (core_rst) hi++; end
        chk("ext_high_cycles", hi, 29);
        chk("ext_boot", boot, 32'hA000_0000);

        // Reset asserted in DRAIN cycle 10
        idle = 1'b0; sw = 1'b1;
        step();
        sw = 1'b0;
        repeat (9) step();
        chk("mid_drain_busy", busy, 1);
        chk("mid_drain_core", core_rst, 0);
        rst = 1'b1;
        step();
        chk("mid_rst_core", core_rst, 1);
        chk("mid_rst_boot", boot, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_timeout", timeout, 0);
        pulses = 0;
        step();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && core_rst; i++) begin
            step(); n++;
            if (timeout) pulses++;
        end
        chk("mid_release_high", n, 16);
        chk("mid_release_boot", boot, 32'hA000_0000);
        repeat (280) begin step(); if (timeout) pulses++; end
        chk("mid_no_timeout", pulses, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
